alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked ALU for the datapath execute stage; WIDTH-bit operands.
//  Keeps the existing op_sel encodings (AND/OR/ADD/SUB/SLT/NOR) and adds XOR, shifts, SLTU,
//  an overflow flag and an iterative shift-add multiplier.
//  Single-cycle ops return after 1 clock; MUL takes WIDTH+1 clocks.
//  Sits between decode/issue (in_* side) and writeback (out_* side).
// PARAMETERS
//  WIDTH   64  operand/result width; power of 2, >= 8
//  MUL_EN  1   1 = MUL implemented; 0 = op 10 treated as illegal
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      block can accept a request (high only in IDLE)
//  src1       in   WIDTH  operand A
//  src2       in   WIDTH  operand B; shift amount = src2[$clog2(WIDTH)-1:0]
//  op_sel     in   4      0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT, 8 SRA,
//                         9 SLTU, 10 MUL (low WIDTH bits), 12 NOR; 11, 13-15 illegal
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0
//  overflow   out  1      signed overflow; ADD/SUB only, else 0
//  illegal    out  1      op_sel was illegal
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; result=0; zero=0; overflow=0; illegal=0; MUL counter=0.
//  FSM: IDLE, MUL_BUSY, DONE.
//   IDLE: accept when in_valid && in_ready. Operands and op_sel are captured at the accepting edge.
//     Non-MUL ops: result/flags are computed and registered at the same edge; go to DONE.
//     MUL: load accumulator=0, multiplicand=src1, multiplier=src2, count=0; go to MUL_BUSY.
//   MUL_BUSY: one multiplier bit per cycle (LSB first; add multiplicand if bit set; shift).
//     After WIDTH iterations, register the low WIDTH bits and flags; go to DONE.
//   DONE: out_valid=1. Outputs are held stable until out_valid && out_ready, then go to IDLE.
//  Latency, counted in edges from the accepting edge to out_valid high:
//     1 for non-MUL ops; WIDTH+1 for MUL.
//  No overlap: in_ready=0 in MUL_BUSY and DONE. in_valid in those states is ignored, not queued.
//   A new request is accepted no earlier than the edge after the out handshake.
//  Arithmetic:
//   - ADD/SUB are modulo 2^WIDTH.
//   - overflow = operand signs equal (ADD) or different (SUB), and result sign differs from src1.
//   - SLT is signed and SLTU is unsigned; both produce 0 or 1 in bit 0.
//   - SRA replicates src1[WIDTH-1]; shift amount 0 passes src1 through.
//   - MUL is unsigned and keeps the low WIDTH bits; the product is identical for signed operands.
//  Illegal op: result=0, zero=1, illegal=1, overflow=0; latency 1.
//  zero is computed from the registered result in every case.
//  reset in any state (including mid-MUL) applies the reset values at that edge.
//   Any in-flight operation is discarded; the next request is accepted normally.
//  reset and in_valid in the same cycle: reset wins; the request is not accepted.
// TESTING (WIDTH=64)
//  ADD 64+100 -> result 164, zero 0, overflow 0, out_valid 1 edge after accept; in_ready 0 until out handshake.
//  SUB 64-64 -> result 0, zero 1; SLT 4,5 -> 1; SLT 0xFFFF_FFFF_FFFF_FFFF,1 -> 1; SLTU same operands -> 0.
//  MUL 0x1_0000_0001 * 3 -> 0x3_0000_0003 exactly 65 edges after accept;
//    in_valid pulses during MUL_BUSY are ignored.
//  Backpressure: out_ready held 0 for 5 cycles after out_valid -> result/flags stable, in_ready 0;
//    then out_ready=1 -> IDLE the next edge.
//  reset at edge 10 of a MUL -> out_valid 0, in_ready 1, result 0;
//    a following ADD 1+1 -> result 2 with 1-edge latency.
//  ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> result 0x8000_0000_0000_0000, overflow 1;
//    op_sel 13 -> result 0, zero 1, illegal 1; MUL_EN=0 with op 10 -> illegal 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with an iterative shift-add MUL.
// Ports:
//   clk, reset         clock (rising edge), synchronous active-high reset
//   in_valid/in_ready  request handshake; in_ready high only when idle
//   src1, src2         operands; src2 low bits give the shift amount
//   op_sel             0 AND 1 OR 2 ADD 3 XOR 4 SLL 5 SRL 6 SUB 7 SLT
//                      8 SRA 9 SLTU 10 MUL 12 NOR; others illegal
//   out_valid/out_ready result handshake; outputs held until taken
//   result, zero       registered result and its zero flag
//   overflow, illegal  signed ADD/SUB overflow, illegal op_sel
module alu_seq #(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_ill;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SW-1:0]    r_cnt;

    logic [SW-1:0]    w_sh;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_illegal;
    logic             w_is_mul;
    logic             w_accept;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_sh       = src2[SW-1:0];
    assign w_sum      = src1 + src2;
    assign w_dif      = src1 - src2;
    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_mul_last = (r_cnt == CNT_LAST);
    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        unique case (op_sel)
            4'd0: w_res = src1 & src2;
            4'd1: w_res = src1 | src2;
            4'd2: begin
                w_res = w_sum;
                w_ovf = (src1[MSB] == src2[MSB]) &&
                        (w_sum[MSB] != src1[MSB]);
            end
            4'd3: w_res = src1 ^ src2;
            4'd4: w_res = src1 << w_sh;
            4'd5: w_res = src1 >> w_sh;
            4'd6: begin
                w_res = w_dif;
                w_ovf = (src1[MSB] != src2[MSB]) &&
                        (w_dif[MSB] != src1[MSB]);
            end
            4'd7: w_res = {{(WIDTH-1){1'b0}},
                           ($signed(src1) < $signed(src2))};
            4'd8: w_res = $signed(src1) >>> w_sh;
            4'd9: w_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            4'd12: w_res = ~(src1 | src2);
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        unique case (op_sel)
            4'd10: begin
                w_illegal = !MUL_EN;
                w_is_mul  = MUL_EN;
            end
            4'd11, 4'd13, 4'd14, 4'd15: w_illegal = 1'b1;
            default: w_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (w_is_mul && !w_illegal) ?
                                  S_MUL_BUSY : S_DONE;
                end
            end
            S_MUL_BUSY: begin
                if (w_mul_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The last multiplier iteration and the result write share one
    // edge, so MUL spends exactly WIDTH edges in MUL_BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            if (w_illegal) begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_ovf    <= 1'b0;
                r_ill    <= 1'b1;
            end else if (w_is_mul) begin
                r_acc    <= '0;
                r_mcand  <= src1;
                r_mplier <= src2;
                r_cnt    <= '0;
            end else begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_ovf    <= w_ovf;
                r_ill    <= 1'b0;
            end
        end else if (r_state == S_MUL_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_result <= w_acc_nxt;
                r_zero   <= (w_acc_nxt == '0);
                r_ovf    <= 1'b0;
                r_ill    <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign illegal   = r_ill;

endmodule
